// File: rtl/product_accumulator.sv
// Sums blocks of COUNT unsigned products from the multiplier and presents each block sum
// on a valid/ready output, holding it until the consumer takes it.
module product_accumulator #(
  parameter int unsigned PROD_W = 16,
  parameter int unsigned COUNT  = 4,
  parameter int unsigned ACC_W  = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_overflow,
  output logic [7:0]        in_count
);

  typedef enum logic [0:0] {StAccum, StHold} state_e;

  state_e             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic               ovf_q;
  logic [ACC_W:0]     sum;
  logic               last;

  // Extra top bit captures the carry out of the accumulator width.
  assign sum  = {1'b0, acc_q} + {1'b0, ACC_W'(in_product)};
  assign last = (in_count == 8'(COUNT - 1));

  // Both handshake outputs are pure functions of the registered state.
  assign in_ready  = (state_q == StAccum);
  assign out_valid = (state_q == StHold);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StAccum;
      acc_q        <= '0;
      ovf_q        <= 1'b0;
      in_count     <= '0;
      out_sum      <= '0;
      out_overflow <= 1'b0;
    end else begin
      unique case (state_q)
        StAccum: begin
          if (clear) begin
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            in_count <= '0;
          end else if (in_valid) begin
            if (last) begin
              out_sum      <= sum[ACC_W-1:0];
              out_overflow <= ovf_q | sum[ACC_W];
              acc_q        <= '0;
              ovf_q        <= 1'b0;
              in_count     <= '0;
              state_q      <= StHold;
            end else begin
              acc_q    <= sum[ACC_W-1:0];
              ovf_q    <= ovf_q | sum[ACC_W];
              in_count <= in_count + 8'd1;
            end
          end
        end
        StHold: begin
          if (out_ready) begin
            state_q <= StAccum;
          end
        end
        default: state_q <= StAccum;
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator: a 20-bit and a 16-bit accumulator instance,
// directed blocks push expected sums, negedge monitors pop on each output transfer.
module tb_product_accumulator;

  typedef struct {
    logic [19:0] sum;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        clear;
  logic        out_ready;
  logic [15:0] in_product;
  logic        sel;

  logic        a_in_ready, a_out_valid, a_out_overflow;
  logic [19:0] a_out_sum;
  logic [7:0]  a_in_count;
  logic        b_in_ready, b_out_valid, b_out_overflow;
  logic [15:0] b_out_sum;
  logic [7:0]  b_in_count;

  exp_t exp_a[$];
  exp_t exp_b[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  product_accumulator #(.PROD_W(16), .COUNT(4), .ACC_W(20)) u_dut_a (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid & ~sel),
    .in_ready     (a_in_ready),
    .in_product   (in_product),
    .clear        (clear & ~sel),
    .out_valid    (a_out_valid),
    .out_ready    (out_ready),
    .out_sum      (a_out_sum),
    .out_overflow (a_out_overflow),
    .in_count     (a_in_count)
  );

  product_accumulator #(.PROD_W(16), .COUNT(4), .ACC_W(16)) u_dut_b (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid & sel),
    .in_ready     (b_in_ready),
    .in_product   (in_product),
    .clear        (clear & sel),
    .out_valid    (b_out_valid),
    .out_ready    (out_ready),
    .out_sum      (b_out_sum),
    .out_overflow (b_out_overflow),
    .in_count     (b_in_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change only 1 time unit after the rising edge, so negedge sampling is stable.
  always @(negedge clk) begin
    if (reset && a_out_valid && out_ready) begin
      if (exp_a.size() == 0) begin
        check("a_unexpected_output", 32'(a_out_sum), 32'hdead);
      end else begin
        exp_t e;
        e = exp_a.pop_front();
        check("a_out_sum", 32'(a_out_sum), 32'(e.sum));
        check("a_out_overflow", 32'(a_out_overflow), 32'(e.ovf));
      end
    end
    if (reset && b_out_valid && out_ready) begin
      if (exp_b.size() == 0) begin
        check("b_unexpected_output", 32'(b_out_sum), 32'hdead);
      end else begin
        exp_t e;
        e = exp_b.pop_front();
        check("b_out_sum", 32'(b_out_sum), 32'(e.sum[15:0]));
        check("b_out_overflow", 32'(b_out_overflow), 32'(e.ovf));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] p);
    in_valid   = 1'b1;
    in_product = p;
    tick();
    in_valid   = 1'b0;
  endtask

  task automatic push(input logic [19:0] s, input logic o);
    exp_t e;
    e.sum = s;
    e.ovf = o;
    if (sel) exp_b.push_back(e);
    else     exp_a.push_back(e);
  endtask

  // Four back-to-back products, then the single HOLD bubble with out_ready high.
  task automatic block(input logic [15:0] p0, input logic [15:0] p1,
                       input logic [15:0] p2, input logic [15:0] p3);
    send(p0);
    send(p1);
    send(p2);
    send(p3);
    tick();
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_out_valid"}, 32'(a_out_valid), 32'd0);
    check({tag, "_out_sum"}, 32'(a_out_sum), 32'd0);
    check({tag, "_out_overflow"}, 32'(a_out_overflow), 32'd0);
    check({tag, "_in_count"}, 32'(a_in_count), 32'd0);
    check({tag, "_in_ready"}, 32'(a_in_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
    in_product = '0; sel = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    check_reset_a("reset");

    // Basic block with immediate consumption: one-cycle bubble.
    push(20'h0000A, 1'b0);
    send(16'h0001); send(16'h0002); send(16'h0003); send(16'h0004);
    check("blk_in_ready_hold", 32'(a_in_ready), 32'd0);
    check("blk_out_valid", 32'(a_out_valid), 32'd1);
    tick();
    check("blk_in_ready_back", 32'(a_in_ready), 32'd1);
    check("blk_out_valid_drop", 32'(a_out_valid), 32'd0);

    // Backpressure: result held stable, input pulses ignored.
    out_ready = 1'b0;
    push(20'h0000A, 1'b0);
    send(16'h0001); send(16'h0002); send(16'h0003); send(16'h0004);
    for (int i = 0; i < 5; i++) begin
      in_valid   = i[0];
      in_product = 16'h0055;
      tick();
      check("bp_out_valid", 32'(a_out_valid), 32'd1);
      check("bp_out_sum", 32'(a_out_sum), 32'h0000A);
      check("bp_in_ready", 32'(a_in_ready), 32'd0);
      check("bp_in_count", 32'(a_in_count), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_out_valid", 32'(a_out_valid), 32'd0);
    check("bp_release_in_ready", 32'(a_in_ready), 32'd1);
    check("bp_sum_retained", 32'(a_out_sum), 32'h0000A);

    // Max values on the wide accumulator.
    push(20'h3FFFC, 1'b0);
    block(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);

    // Narrow accumulator: wrap with sticky overflow, then a clean block.
    sel = 1'b1;
    push(20'h00001, 1'b1);
    block(16'hFFFF, 16'h0002, 16'h0000, 16'h0000);
    push(20'h00004, 1'b0);
    block(16'h0001, 16'h0001, 16'h0001, 16'h0001);
    sel = 1'b0;

    // Clear beats a simultaneous product.
    send(16'h0010); send(16'h0020);
    check("clr_count_before", 32'(a_in_count), 32'd2);
    clear = 1'b1; in_valid = 1'b1; in_product = 16'h0030;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    check("clr_count_after", 32'(a_in_count), 32'd0);
    push(20'h0001A, 1'b0);
    block(16'h0005, 16'h0006, 16'h0007, 16'h0008);

    // Clear together with the COUNT-th product: block not completed.
    send(16'h0001); send(16'h0002); send(16'h0003);
    clear = 1'b1; in_valid = 1'b1; in_product = 16'h0004;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    check("clr_last_count", 32'(a_in_count), 32'd0);
    check("clr_last_out_valid", 32'(a_out_valid), 32'd0);

    // Gappy input.
    push(20'h00A00, 1'b0);
    send(16'h0100);
    check("gap_count1", 32'(a_in_count), 32'd1);
    tick(); tick(); tick();
    check("gap_count1_idle", 32'(a_in_count), 32'd1);
    send(16'h0200);
    check("gap_count2", 32'(a_in_count), 32'd2);
    tick();
    send(16'h0300);
    check("gap_count3", 32'(a_in_count), 32'd3);
    send(16'h0400);
    check("gap_out_valid", 32'(a_out_valid), 32'd1);
    tick();

    // Reset mid-block.
    send(16'h0001); send(16'h0002);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_reset_a("rst_mid");

    // Reset while holding an unconsumed result.
    out_ready = 1'b0;
    send(16'h0001); send(16'h0002); send(16'h0003); send(16'h0004);
    check("rst_hold_pre_valid", 32'(a_out_valid), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    check_reset_a("rst_hold");

    push(20'h0000A, 1'b0);
    block(16'h0001, 16'h0002, 16'h0003, 16'h0004);

    tick(); tick();
    check("a_queue_drained", 32'(exp_a.size()), 32'd0);
    check("b_queue_drained", 32'(exp_b.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Downstream stage of the 8x8 shift-add multiplier. Accepts one 16-bit product per valid/ready handshake, sums a block of COUNT consecutive products, then presents the block sum on a valid/ready output port until the consumer takes it. Used for dot-product and MAC-style reductions on multiplier results without software summation.

## Interface
- PROD_W, 16, width of incoming product.
- COUNT, 4, products per block; legal range 1..255.
- ACC_W, 20, accumulator/output width; must be >= PROD_W.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  in_product is valid this cycle.
- in_ready  out  1  block can accept a product this cycle.
- in_product  in  PROD_W  product from multiplier, unsigned.
- clear  in  1  synchronous abort of the current partial block.
- out_valid  out  1  out_sum/out_overflow hold a completed block.
- out_ready  in  1  consumer takes the result this cycle.
- out_sum  out  ACC_W  block sum, modulo 2^ACC_W.
- out_overflow  out  1  carry out of ACC_W occurred during the block.
- in_count  out  8  products accepted in current block.

## Operation
- Two states: ACCUM, HOLD. Reset state ACCUM.
- Reset (reset=0 at a clk edge): state=ACCUM, accumulator=0, in_count=0, overflow flag=0, out_sum=0, out_overflow=0, out_valid=0. in_ready=1 after reset is released. Reset overrides all other inputs, including mid-block and in HOLD; a partial block or an unconsumed result is discarded.
- ACCUM: in_ready=1, out_valid=0.
  - clear=1: accumulator, in_count and overflow flag go to 0. Any in_valid in the same cycle is dropped. clear has priority.
  - in_valid=1, clear=0: accept in_product, zero-extended to ACC_W. accumulator += product, modulo 2^ACC_W. Carry out of bit ACC_W-1 sets the sticky overflow flag. in_count increments.
  - Accepting product number COUNT: out_sum is loaded with the final sum and out_overflow with the final flag. The accumulator, in_count and flag are zeroed. State goes to HOLD.
- HOLD: in_ready=0, out_valid=1. out_sum and out_overflow are stable.
  - in_valid is ignored. clear is ignored.
  - out_ready=1: state goes to ACCUM and out_valid drops next cycle. out_sum and out_overflow keep their last values.
- Arithmetic is unsigned only. Sums wrap.
- With the default widths, COUNT <= 16 cannot overflow.

## Timing
- Handshake on each port is a transfer when valid and ready are both 1 at a rising clk edge.
- Throughput is 1 product per cycle within a block.
- The last product is accepted at edge N. out_valid=1 from edge N, visible in the cycle after edge N.
- Earliest completion is COUNT cycles after the first accept.
- Bubble: in_ready=0 for every HOLD cycle. Minimum 1 cycle per block if out_ready is held at 1.
- in_ready depends on state only, not on in_valid. No combinational path from in_valid to in_ready.
- out_valid is registered. It does not depend combinationally on out_ready.
- COUNT=1: each accepted product goes directly to HOLD. out_sum = product.
- clear in the same cycle as the COUNT-th in_valid: clear wins. The block is not completed and in_count becomes 0.

## Test plan
- Reset then block, COUNT=4: reset=0 for 2 cycles, then release. Apply products 0x0001, 0x0002, 0x0003, 0x0004 on back-to-back cycles, out_ready=1. Expect out_valid for 1 cycle, out_sum=0x0000A, out_overflow=0, and in_ready=0 for exactly 1 cycle.
- Backpressure: same block with out_ready=0 for 5 cycles. Expect out_valid=1 and out_sum=0x0000A held stable, in_ready=0, and in_valid pulses ignored. Raise out_ready and expect out_valid=0 and in_ready=1 the next cycle.
- Max values: four products of 0xFFFF. Expect out_sum=0x3FFFC and out_overflow=0. Then run ACC_W=16 with products 0xFFFF, 0x0002, 0x0000, 0x0000. Expect out_sum=0x0001 and out_overflow=1. A following block 1,1,1,1 must give out_sum=0x0004 and out_overflow=0.
- Clear: accept 0x0010 and 0x0020, then assert clear together with in_valid for 0x0030. Expect in_count=0. Then feed 5, 6, 7, 8 and expect out_sum=0x0001A.
- Gappy input: 0x0100, idle 3 cycles, 0x0200, idle 1 cycle, 0x0300, 0x0400. Expect in_count to step 1, 2, 3 and out_sum=0x00A00.
- Reset mid-operation: assert reset after 2 of 4 products, and separately while in HOLD. Expect every output at its reset value next cycle. A following block 1, 2, 3, 4 must give 0x0000A.
